gam_subset_fetch: RTL

- Downstream of the gamma parameter interface.
- On that block's done strobe it latches the subset's base address, integer pixel count and centre (cx, cy).
- It then reads the subset's pixels from the image BRAM and streams them out with a valid/ready handshake.
- It accumulates a running pixel sum for the correlation stage that follows.

---
 rtl/gam_subset_fetch_pkg.sv | 15 +
 rtl/gam_pix_fifo.sv | 65 ++++++
 rtl/gam_subset_fetch.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/gam_subset_fetch_pkg.sv
// Shared state encoding and constants for the gamma subset fetch block.
// The read latency default matches the image BRAM timing used by the gamma interface.
package gam_subset_fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } fetch_state_t;

   localparam int BYTES_PER_WORD = 4;
   localparam int DEFAULT_RD_LAT = 3;

endpackage

// File: rtl/gam_pix_fifo.sv
// Small synchronous FIFO that buffers BRAM read data ahead of the pixel handshake.
// The head word is visible on o_data whenever o_empty is low.
module gam_pix_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty,
   output logic [CNT_W-1:0] o_count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wrPtr;
   logic [PTR_W-1:0] r_rdPtr;
   logic [CNT_W-1:0] r_count;
   logic             w_pop;

   function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign w_pop   = i_pop && (r_count != '0);
   assign o_data  = r_mem[r_rdPtr];
   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

   always_ff @(posedge clock) begin
      if (i_push) begin
         r_mem[r_wrPtr] <= i_data;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (i_push) begin
            r_wrPtr <= nextPtr(r_wrPtr);
         end
         if (w_pop) begin
            r_rdPtr <= nextPtr(r_rdPtr);
         end
         case ({i_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Upstream credit accounting must never let a push land on a full buffer.
   a_noOverflow: assert property (@(posedge clock) disable iff (!reset_n) !(i_push && o_full));

endmodule

// File: rtl/gam_subset_fetch.sv
// Fetches one correlation subset from the image BRAM on a start edge and streams
// its pixels out over valid/ready while accumulating their running sum.
module gam_subset_fetch
   import gam_subset_fetch_pkg::*;
#(
   parameter int RD_LAT     = DEFAULT_RD_LAT,
   parameter int FIFO_DEPTH = 4,
   parameter int SUM_W      = 48
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic [31:0]      base_addr,
   input  logic [31:0]      num_pxl,
   input  logic [31:0]      cx_in,
   input  logic [31:0]      cy_in,
   output logic             img_ea,
   output logic [3:0]       img_wea,
   output logic [31:0]      img_addr,
   input  logic [31:0]      img_dout,
   output logic [31:0]      pix_data,
   output logic [31:0]      pix_idx,
   output logic             pix_valid,
   input  logic             pix_ready,
   output logic             pix_last,
   output logic [31:0]      sub_cx,
   output logic [31:0]      sub_cy,
   output logic [SUM_W-1:0] pix_sum,
   output logic             busy,
   output logic             done
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   fetch_state_t      r_state;
   fetch_state_t      w_stateNext;
   logic              r_startQ;
   logic              w_trigger;
   logic [RD_LAT-1:0] r_rdPipe;
   logic [31:0]       r_base;
   logic [31:0]       r_num;
   logic [31:0]       r_issued;
   logic [31:0]       r_accepted;
   logic [SUM_W-1:0]  r_sum;
   logic [31:0]       r_subCx;
   logic [31:0]       r_subCy;
   logic [31:0]       w_outstanding;
   logic              w_issue;
   logic              w_pop;
   logic [31:0]       w_fifoData;
   logic              w_fifoFull;
   logic              w_fifoEmpty;
   logic [CNT_W-1:0]  w_fifoCount;

   gam_pix_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .i_push  (r_rdPipe[RD_LAT-1]),
      .i_data  (img_dout),
      .i_pop   (w_pop),
      .o_data  (w_fifoData),
      .o_full  (w_fifoFull),
      .o_empty (w_fifoEmpty),
      .o_count (w_fifoCount)
   );

   assign w_trigger = start & ~r_startQ;
   assign w_pop     = pix_valid & pix_ready;

   assign pix_valid = ~w_fifoEmpty;
   assign pix_data  = pix_valid ? w_fifoData : '0;
   assign pix_idx   = r_accepted;
   assign pix_last  = pix_valid && (r_accepted == r_num - 32'd1);
   assign pix_sum   = r_sum;
   assign sub_cx    = r_subCx;
   assign sub_cy    = r_subCy;
   assign busy      = (r_state == ISSUE) || (r_state == DRAIN);
   assign done      = (r_state == DONE);
   assign img_ea    = w_issue;
   assign img_wea   = '0;
   assign img_addr  = w_issue ? r_base + r_issued * 32'(BYTES_PER_WORD) : '0;

   // A pop this cycle frees its slot immediately, which keeps one pixel per cycle
   // flowing when the buffer is only RD_LAT+1 deep.
   always_comb begin
      w_outstanding = 32'(w_fifoCount);
      for (int i = 0; i < RD_LAT; i++) begin
         w_outstanding = w_outstanding + 32'(r_rdPipe[i]);
      end
      if (w_pop) begin
         w_outstanding = w_outstanding - 32'd1;
      end
      w_issue = (r_state == ISSUE) && (r_issued < r_num) && !w_fifoFull &&
                (w_outstanding < 32'(FIFO_DEPTH));
      w_stateNext = r_state;
      case (r_state)
         IDLE:    if (w_trigger) w_stateNext = (num_pxl == 32'd0) ? DONE : ISSUE;
         ISSUE:   if (r_issued + 32'(w_issue) == r_num) w_stateNext = DRAIN;
         DRAIN:   if (r_accepted == r_num) w_stateNext = DONE;
         DONE:    w_stateNext = IDLE;
         default: w_stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_startQ   <= 1'b0;
         r_rdPipe   <= '0;
         r_base     <= '0;
         r_num      <= '0;
         r_issued   <= '0;
         r_accepted <= '0;
         r_sum      <= '0;
         r_subCx    <= '0;
         r_subCy    <= '0;
      end else begin
         r_startQ <= start;
         r_rdPipe <= {r_rdPipe[RD_LAT-2:0], w_issue};
         if (r_state == IDLE && w_trigger) begin
            r_base     <= base_addr;
            r_num      <= num_pxl;
            r_subCx    <= cx_in;
            r_subCy    <= cy_in;
            r_issued   <= '0;
            r_accepted <= '0;
            r_sum      <= '0;
         end else begin
            if (w_issue) begin
               r_issued <= r_issued + 32'd1;
            end
            if (w_pop) begin
               r_accepted <= r_accepted + 32'd1;
               r_sum      <= r_sum + SUM_W'(w_fifoData);
            end
         end
      end
   end

endmodule
